// File: rtl/t05_bit_packer.sv
// Serial-to-byte packer: MSB-first byte assembly, show-ahead byte FIFO, flush/pad/drain control.
// Optional feature macro T05_PACKER_BITCOUNT_EN builds the saturating absorbed-bit counter.
module t05_bit_packer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bit_valid,
    input  logic              i_bit_in,
    input  logic              i_flush,
    input  logic              i_byte_ready,
    output logic              o_byte_valid,
    output logic [7:0]        o_byte_data,
    output logic [ADDR_W-1:0] o_byte_addr,
    output logic [15:0]       o_bit_total,
    output logic              o_flush_done,
    output logic              o_overflow,
    output logic              o_busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAD   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [6:0]        r_sr;
    logic [2:0]        r_bcnt;
    logic [7:0]        r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_valid;
    logic [7:0]        r_head;
    logic [ADDR_W-1:0] r_addr;
    logic              r_flush_done;
    logic              r_overflow;
    logic              r_busy;

    logic [6:0]        w_sr_nxt;
    logic [2:0]        w_bcnt_nxt;
    logic              w_push_req;
    logic [7:0]        w_push_data;
    logic              w_push_ok;
    logic              w_pop;
    logic              w_full;
    logic              w_absorb;
    logic              w_bit_drop;
    logic              w_done;
    logic [7:0]        w_pad_byte;
    logic [CW-1:0]     w_count_nxt;
    logic [PW-1:0]     w_rptr_nxt;
    logic [7:0]        w_head_nxt;

    assign w_full     = (r_count == CNT_FULL);
    assign w_pop      = r_valid && i_byte_ready;
    assign w_pad_byte = {1'b0, r_sr} << (4'd8 - {1'b0, r_bcnt});
    assign w_push_ok  = w_push_req && (!w_full || w_pop);

    // Next-state and datapath control for RUN/PAD/DRAIN
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_bcnt_nxt  = r_bcnt;
        w_push_req  = 1'b0;
        w_push_data = 8'h00;
        w_absorb    = 1'b0;
        w_bit_drop  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_bit_valid) begin
                    w_absorb   = 1'b1;
                    w_sr_nxt   = {r_sr[5:0], i_bit_in};
                    w_bcnt_nxt = r_bcnt + 3'd1;
                    if (r_bcnt == 3'd7) begin
                        w_push_req  = 1'b1;
                        w_push_data = {r_sr, i_bit_in};
                    end else begin
                        w_push_req  = 1'b0;
                    end
                end else begin
                    w_absorb = 1'b0;
                end
                if (i_flush) begin
                    w_state_nxt = (w_bcnt_nxt != 3'd0) ? ST_PAD : ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_PAD: begin
                w_bit_drop = i_bit_valid;
                // The pad byte waits for room; it is never dropped.
                if (!w_full || w_pop) begin
                    w_push_req  = 1'b1;
                    w_push_data = w_pad_byte;
                    w_sr_nxt    = 7'd0;
                    w_bcnt_nxt  = 3'd0;
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_PAD;
                end
            end
            ST_DRAIN: begin
                w_bit_drop = i_bit_valid;
                if (r_count == CNT_ZERO) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // FIFO occupancy, read pointer and registered show-ahead head byte
    always_comb begin
        w_rptr_nxt = w_pop ? (r_rptr + PTR_ONE) : r_rptr;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
        if (w_count_nxt == CNT_ZERO) begin
            w_head_nxt = 8'h00;
        end else if (w_push_ok && (r_wptr == w_rptr_nxt)) begin
            w_head_nxt = w_push_data;
        end else begin
            w_head_nxt = r_mem[w_rptr_nxt];
        end
    end

    // FIFO storage; contents are discarded on reset through the pointers
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    // Control, pointer, counter and flag registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_RUN;
            r_sr         <= 7'd0;
            r_bcnt       <= 3'd0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= CNT_ZERO;
            r_valid      <= 1'b0;
            r_head       <= 8'h00;
            r_addr       <= '0;
            r_flush_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sr         <= w_sr_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_wptr       <= w_push_ok ? (r_wptr + PTR_ONE) : r_wptr;
            r_rptr       <= w_rptr_nxt;
            r_count      <= w_count_nxt;
            r_valid      <= (w_count_nxt != CNT_ZERO);
            r_head       <= w_head_nxt;
            r_addr       <= w_pop ? (r_addr + ADDR_W'(1)) : r_addr;
            r_flush_done <= w_done;
            r_overflow   <= r_overflow || w_bit_drop || (w_push_req && !w_push_ok);
            r_busy       <= (w_state_nxt == ST_PAD) || (w_state_nxt == ST_DRAIN);
        end
    end

`ifdef T05_PACKER_BITCOUNT_EN
    logic [15:0] r_bit_total;

    // Saturating count of bits absorbed in RUN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit_total <= 16'h0000;
        end else if (w_absorb && (r_bit_total != 16'hFFFF)) begin
            r_bit_total <= r_bit_total + 16'h0001;
        end else begin
            r_bit_total <= r_bit_total;
        end
    end

    assign o_bit_total = r_bit_total;
`else
    assign o_bit_total = 16'h0000;
`endif

    assign o_byte_valid = r_valid;
    assign o_byte_data  = r_head;
    assign o_byte_addr  = r_addr;
    assign o_flush_done = r_flush_done;
    assign o_overflow   = r_overflow;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_t05_bit_packer.sv
// Self-checking bench for t05_bit_packer: directed scenarios plus randomized run against a queue model.
module tb_t05_bit_packer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;

    logic              clk;
    logic              rst;
    logic              bit_valid;
    logic              bit_in;
    logic              flush;
    logic              byte_ready;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic [ADDR_W-1:0] byte_addr;
    logic [15:0]       bit_total;
    logic              flush_done;
    logic              overflow;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    t05_bit_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_bit_valid  (bit_valid),
        .i_bit_in     (bit_in),
        .i_flush      (flush),
        .i_byte_ready (byte_ready),
        .o_byte_valid (byte_valid),
        .o_byte_data  (byte_data),
        .o_byte_addr  (byte_addr),
        .o_bit_total  (bit_total),
        .o_flush_done (flush_done),
        .o_overflow   (overflow),
        .o_busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bytes handed downstream and flush_done pulses, observed mid-cycle
    logic [7:0] got_q[$];
    int         fd_cnt;
    always @(negedge clk) begin
        if (!rst && byte_valid && byte_ready) got_q.push_back(byte_data);
        if (!rst && flush_done) fd_cnt++;
    end

    // Behavioural reference: bit accumulator, byte queue, phase 0=run 1=pad 2=drain
    int         m_phase;
    int         m_acc;
    int         m_n;
    logic [7:0] m_q[$];
    logic [15:0] m_addr;
    logic [15:0] m_total;
    bit         m_ovf;
    bit         m_fd;

    task automatic model_reset();
        m_phase = 0; m_acc = 0; m_n = 0; m_q.delete();
        m_addr = 16'h0; m_total = 16'h0; m_ovf = 1'b0; m_fd = 1'b0;
    endtask

    task automatic model_step(input bit bv, input bit bi, input bit fl, input bit rdy);
        int sz0;
        bit pop;
        bit room;
        sz0  = m_q.size();
        pop  = (sz0 > 0) && rdy;
        room = (sz0 < DEPTH) || pop;
        m_fd = 1'b0;
        if (pop) begin
            void'(m_q.pop_front());
            m_addr = m_addr + 16'h1;
        end
        case (m_phase)
            0: begin
                if (bv) begin
                    if (m_total != 16'hFFFF) m_total = m_total + 16'h1;
                    m_acc = m_acc * 2 + int'(bi);
                    m_n++;
                    if (m_n == 8) begin
                        if (room) m_q.push_back(8'(m_acc));
                        else m_ovf = 1'b1;
                        m_acc = 0;
                        m_n   = 0;
                    end
                end
                if (fl) m_phase = (m_n != 0) ? 1 : 2;
            end
            1: begin
                if (bv) m_ovf = 1'b1;
                if (room) begin
                    m_q.push_back(8'(m_acc << (8 - m_n)));
                    m_acc = 0; m_n = 0; m_phase = 2;
                end
            end
            default: begin
                if (bv) m_ovf = 1'b1;
                if (sz0 == 0) begin
                    m_fd    = 1'b1;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    function automatic logic [15:0] exp_total(input logic [15:0] n);
`ifdef T05_PACKER_BITCOUNT_EN
        return n;
`else
        return 16'h0000;
`endif
    endfunction

    // One clock: apply inputs, advance the model on the edge, settle
    task automatic drive(input bit bv, input bit bi, input bit fl, input bit rdy);
        bit_valid = bv; bit_in = bi; flush = fl; byte_ready = rdy;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(bv, bi, fl, rdy);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        got_q.delete();
        fd_cnt = 0;
    endtask

    bit bits[64];
    function automatic logic [7:0] byte_of(input int k);
        int v = 0;
        for (int i = 0; i < 8; i++) v = v * 2 + int'(bits[8*k + i]);
        return 8'(v);
    endfunction

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (byte_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", byte_valid); end
        if (byte_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%02h exp=00", byte_data); end
        if (byte_addr !== 16'h0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", byte_addr); end
        if (bit_total !== 16'h0) begin failures++; $display("FAIL reset_total got=%0d exp=0", bit_total); end
        if (flush_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%0b exp=0", flush_done); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_single_byte();
        logic [7:0] pat;
        pat = 8'hB2;
        do_reset();
        for (int i = 7; i >= 1; i--) drive(1'b1, pat[i], 1'b0, 1'b1);
        checks++;
        if (byte_valid !== 1'b0) begin failures++; $display("FAIL early_valid got=%0b exp=0", byte_valid); end
        drive(1'b1, pat[0], 1'b0, 1'b1);
        checks += 2;
        if (byte_valid !== 1'b1) begin failures++; $display("FAIL byte_latency got=%0b exp=1", byte_valid); end
        if (byte_data !== 8'hB2) begin failures++; $display("FAIL byte_b2 got=%02h exp=b2", byte_data); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks += 3;
        if (byte_addr !== 16'd1) begin failures++; $display("FAIL addr_after_pop got=%0d exp=1", byte_addr); end
        if (byte_valid !== 1'b0) begin failures++; $display("FAIL valid_after_pop got=%0b exp=0", byte_valid); end
        if (bit_total !== exp_total(16'd8)) begin failures++; $display("FAIL total_8 got=%0d exp=%0d", bit_total, exp_total(16'd8)); end
    endtask

    task automatic test_flush_partial();
        bit hdr[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int n;
        do_reset();
        foreach (hdr[i]) drive(1'b1, hdr[i], 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL pad_busy got=%0b exp=1", busy); end
        n = 0;
        while (fd_cnt == 0 && n < 20) begin drive(1'b0, 1'b0, 1'b0, 1'b1); n++; end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks += 6;
        if (fd_cnt !== 1) begin failures++; $display("FAIL flush_done_count got=%0d exp=1", fd_cnt); end
        if (got_q.size() !== 2) begin failures++; $display("FAIL flush_bytes got=%0d exp=2", got_q.size()); end
        if (got_q.size() > 0 && got_q[0] !== 8'hA0) begin failures++; $display("FAIL flush_b0 got=%02h exp=a0", got_q[0]); end
        if (got_q.size() > 1 && got_q[1] !== 8'h80) begin failures++; $display("FAIL pad_b1 got=%02h exp=80", got_q[1]); end
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_flush got=%0b exp=0", busy); end
        if (bit_total !== exp_total(16'd11)) begin failures++; $display("FAIL total_11 got=%0d exp=%0d", bit_total, exp_total(16'd11)); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 40; i++) bits[i] = 1'($urandom);
        for (int i = 0; i < 40; i++) drive(1'b1, bits[i], 1'b0, 1'b0);
        checks += 3;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
        if (byte_addr !== 16'd0) begin failures++; $display("FAIL ovf_addr got=%0d exp=0", byte_addr); end
        if (byte_data !== byte_of(0)) begin failures++; $display("FAIL ovf_head got=%02h exp=%02h", byte_data, byte_of(0)); end
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks += 3;
        if (byte_addr !== 16'd4) begin failures++; $display("FAIL ovf_drain_addr got=%0d exp=4", byte_addr); end
        if (got_q.size() !== 4) begin failures++; $display("FAIL ovf_drain_cnt got=%0d exp=4", got_q.size()); end
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== byte_of(k)) begin failures++; $display("FAIL ovf_byte%0d got=%02h exp=%02h", k, got_q[k], byte_of(k)); end
        end
    endtask

    task automatic test_full_simul_pop();
        do_reset();
        for (int i = 0; i < 40; i++) bits[i] = 1'($urandom);
        for (int i = 0; i < 39; i++) drive(1'b1, bits[i], 1'b0, 1'b0);
        drive(1'b1, bits[39], 1'b0, 1'b1);
        checks += 2;
        if (overflow !== 1'b0) begin failures++; $display("FAIL simul_no_ovf got=%0b exp=0", overflow); end
        if (byte_data !== byte_of(1)) begin failures++; $display("FAIL simul_head got=%02h exp=%02h", byte_data, byte_of(1)); end
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks += 2;
        if (got_q.size() !== 5) begin failures++; $display("FAIL simul_total_bytes got=%0d exp=5", got_q.size()); end
        if (byte_addr !== 16'd5) begin failures++; $display("FAIL simul_addr got=%0d exp=5", byte_addr); end
        for (int k = 0; k < 5 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== byte_of(k)) begin failures++; $display("FAIL simul_byte%0d got=%02h exp=%02h", k, got_q[k], byte_of(k)); end
        end
    endtask

    task automatic test_flush_aligned();
        int n;
        do_reset();
        for (int i = 0; i < 16; i++) bits[i] = 1'($urandom);
        for (int i = 0; i < 16; i++) drive(1'b1, bits[i], 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL drain_busy got=%0b exp=1", busy); end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        n = 0;
        while (fd_cnt == 0 && n < 20) begin drive(1'b0, 1'b0, 1'b0, 1'b1); n++; end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks += 5;
        if (got_q.size() !== 2) begin failures++; $display("FAIL aligned_bytes got=%0d exp=2", got_q.size()); end
        if (fd_cnt !== 1) begin failures++; $display("FAIL aligned_fd got=%0d exp=1", fd_cnt); end
        if (overflow !== 1'b1) begin failures++; $display("FAIL drain_bit_ovf got=%0b exp=1", overflow); end
        if (busy !== 1'b0) begin failures++; $display("FAIL aligned_busy got=%0b exp=0", busy); end
        if (bit_total !== exp_total(16'd16)) begin failures++; $display("FAIL total_16 got=%0d exp=%0d", bit_total, exp_total(16'd16)); end
        for (int k = 0; k < 2 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== byte_of(k)) begin failures++; $display("FAIL aligned_byte%0d got=%02h exp=%02h", k, got_q[k], byte_of(k)); end
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks += 4;
        if (got_q.size() !== 1) begin failures++; $display("FAIL rst_mid_cnt got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0 && got_q[0] !== 8'hFF) begin failures++; $display("FAIL rst_mid_byte got=%02h exp=ff", got_q[0]); end
        if (byte_addr !== 16'd1) begin failures++; $display("FAIL rst_mid_addr got=%0d exp=1", byte_addr); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL rst_mid_ovf got=%0b exp=0", overflow); end
    endtask

    task automatic test_random();
        int thr;
        logic [7:0] exp_data;
        int errs;
        errs = 0;
        do_reset();
        thr = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) thr = $urandom_range(5, 95);
            drive($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 39) == 0,
                  $urandom_range(0, 99) < thr);
            exp_data = (m_q.size() > 0) ? m_q[0] : 8'h00;
            checks += 7;
            if (byte_valid !== (m_q.size() > 0)) begin failures++; errs++; if (errs < 10) $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, byte_valid, m_q.size() > 0); end
            if (byte_data !== exp_data) begin failures++; errs++; if (errs < 10) $display("FAIL rnd_data c=%0d got=%02h exp=%02h", c, byte_data, exp_data); end
            if (byte_addr !== m_addr) begin failures++; errs++; if (errs < 10) $display("FAIL rnd_addr c=%0d got=%0d exp=%0d", c, byte_addr, m_addr); end
            if (overflow !== m_ovf) begin failures++; errs++; if (errs < 10) $display("FAIL rnd_ovf c=%0d got=%0b exp=%0b", c, overflow, m_ovf); end
            if (busy !== (m_phase != 0)) begin failures++; errs++; if (errs < 10) $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", c, busy, m_phase != 0); end
            if (flush_done !== m_fd) begin failures++; errs++; if (errs < 10) $display("FAIL rnd_fd c=%0d got=%0b exp=%0b", c, flush_done, m_fd); end
            if (bit_total !== exp_total(m_total)) begin failures++; errs++; if (errs < 10) $display("FAIL rnd_total c=%0d got=%0d exp=%0d", c, bit_total, exp_total(m_total)); end
        end
    endtask

    initial begin
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; flush = 1'b0; byte_ready = 1'b0;
        fd_cnt = 0;
        model_reset();
        test_reset();
        test_single_byte();
        test_flush_partial();
        test_overflow();
        test_full_simul_pop();
        test_flush_aligned();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/t05_bit_packer.md
# t05_bit_packer

Serial-to-byte packer downstream of the Huffman header synthesis stage. It samples the header/code bit stream one bit per qualifying cycle and assembles bytes MSB-first. Completed bytes are buffered in a small show-ahead FIFO and handed to the memory write stage over a valid/ready handshake. On an end-of-write strobe it zero-pads and emits any partial byte, drains, then pulses completion.

## Interface
- `DEPTH`, 4: byte FIFO depth in entries, power of two, ≥2.
- `ADDR_W`, 16: width of the output byte address counter.

- `clk` input 1: system clock, all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `bit_valid` input 1: `bit_in` is sampled on this cycle.
- `bit_in` input 1: serial data bit.
- `flush` input 1: one-cycle end-of-stream strobe; pad and emit the partial byte.
- `byte_ready` input 1: downstream accepts `byte_data` this cycle.
- `byte_valid` output 1: FIFO non-empty.
- `byte_data` output 8: FIFO head byte.
- `byte_addr` output ADDR_W: count of bytes accepted downstream since reset, used as the write address.
- `bit_total` output 16: data bits absorbed since reset (see Configuration).
- `flush_done` output 1: one-cycle pulse when a flush has fully drained.
- `overflow` output 1: sticky flag; a bit or byte was dropped.
- `busy` output 1: high in `PAD` or `DRAIN`.

## Operation
- Datapath: shift register `sr[6:0]` and bit counter `bcnt[2:0]`.
- On `bit_valid` in `RUN`: `sr <= {sr[5:0], bit_in}` and `bcnt <= bcnt+1`.
- When `bcnt==7`, the byte `{sr[6:0], bit_in}` is pushed to the FIFO on that edge and `bcnt` wraps to 0. The first bit received lands in bit 7 of the byte.
- FIFO is show-ahead: `byte_data` = head whenever `byte_valid`.
- Pop occurs when `byte_valid && byte_ready`. Each pop increments `byte_addr`, which wraps modulo 2^ADDR_W.
- Push when full:
  - with a simultaneous pop, the push is accepted and occupancy is unchanged;
  - otherwise the byte is dropped, `overflow <= 1`, and `bcnt` still wraps.
- FSM states `RUN`, `PAD`, `DRAIN`:
  - `RUN`: on `flush`, a `bit_valid` in the same cycle is absorbed first.
    - If the resulting `bcnt != 0`, go to `PAD`.
    - Otherwise go to `DRAIN`.
  - `PAD`: push `{sr, zeros}` left-aligned, i.e. the `n=bcnt` bits in `[7:8-n]` and zeros below, when the FIFO is not full or a pop occurs the same cycle. Then clear `sr`/`bcnt` and go to `DRAIN`. `PAD` waits while the FIFO is full; it never drops the pad byte.
  - `DRAIN`: when the FIFO is empty, pulse `flush_done` for one cycle and return to `RUN`.
- `bit_valid` asserted in `PAD` or `DRAIN`: the bit is dropped and `overflow <= 1`.
- `flush` asserted in `PAD` or `DRAIN` is ignored.
- `overflow` clears only on `rst`.

## Timing
- Reset values: `byte_valid=0`, `byte_data=8'h00` (empty FIFO head reads 0), `byte_addr=0`, `bit_total=0`, `flush_done=0`, `overflow=0`, `busy=0`, FSM=`RUN`, `sr=0`, `bcnt=0`, FIFO empty.
- `rst` mid-operation discards the partial byte and all FIFO contents on the next edge.
- Latency: the 8th bit sampled at edge N gives `byte_valid=1` after edge N; the byte can be popped in the same cycle.
- The handshake completes on any edge with `byte_valid && byte_ready`. `byte_data` stays stable while `byte_valid && !byte_ready`.
- Flush with partial byte and empty FIFO, flush at edge N: `PAD` at N+1, padded byte valid after N+1. With `byte_ready=1`, the pop is at N+2 and `flush_done` is high in the cycle after edge N+3.
- Upstream has no backpressure. Sustained 1 bit/cycle needs `byte_ready` at least once every 8 cycles.

## Configuration
- `T05_PACKER_BITCOUNT_EN` defined:
  - `bit_total` increments on every absorbed `bit_valid` in `RUN`, including bits whose byte was later dropped;
  - pad bits are not counted;
  - the counter saturates at 16'hFFFF.
- Undefined: the counter is not built and `bit_total` is tied to 16'h0000. All other behaviour is identical.

## Test plan
- Bits 1,0,1,1,0,0,1,0 on consecutive cycles, `byte_ready=1` -> one byte 8'hB2, `byte_addr` 0->1, `bit_total=8` (with macro).
- Header bits 1,0,1,0,0,0,0,0,1,0,0 then `flush` -> bytes 8'hA0 then 8'h80. `flush_done` pulses once after both are popped, `busy` is low afterwards, `bit_total=11`.
- `byte_ready=0`, DEPTH=4, 40 bits -> 4 bytes held, 5th dropped, `overflow=1`, `byte_addr=0`. Then `byte_ready=1` -> 4 bytes out, `byte_addr=4`.
- FIFO full with `byte_ready=1` in the same cycle the 8th bit arrives -> push accepted, no overflow, occupancy stays 4.
- 16 bits then `flush` -> exactly 2 bytes and no pad byte; `flush_done` after drain. `bit_valid` during `DRAIN` -> `overflow=1`.
- 5 bits, `rst` for one cycle, then 8 bits 0xFF pattern -> single byte 8'hFF, `byte_addr=1`, `overflow=0`.
